// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider sequencer: FSM states,
// req_op one-hot bit positions and quotient/remainder half positions.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int unsigned OP_DIV_W  = 0;
  localparam int unsigned OP_MOD_W  = 1;
  localparam int unsigned OP_DIV_WU = 2;
  localparam int unsigned OP_MOD_WU = 3;

  // Divider output is {quotient, remainder}: quotient in the upper half.
  localparam int unsigned QUO_HALF = 1;
  localparam int unsigned REM_HALF = 0;

  function automatic logic op_is_signed(input logic [3:0] op);
    return op[OP_DIV_W] | op[OP_MOD_W];
  endfunction

  function automatic logic op_wants_quo(input logic [3:0] op);
    return op[OP_DIV_W] | op[OP_DIV_WU];
  endfunction

endpackage

// File: rtl/div_chan_issue.sv
// Single valid/ready issuer: valid is held while active until the handshake,
// then a sticky accepted flag keeps it low until the owner clears it.
module div_chan_issue (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clr,
  input  logic ready,
  output logic valid,
  output logic done
);

  logic acc_q;

  always_comb begin
    valid = active & ~acc_q;
    done  = acc_q | (valid & ready);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= 1'b0;
    end else if (valid && ready) begin
      acc_q <= 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequences one division request through the signed or unsigned divider unit
// and holds the result on a valid/ready channel. Optional: DIV_ZERO_BYPASS_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  output logic [DATA_W-1:0]   div_dividend,
  output logic [DATA_W-1:0]   div_divisor,
  output logic                sdiv_dend_valid,
  input  logic                sdiv_dend_ready,
  output logic                sdiv_dsor_valid,
  input  logic                sdiv_dsor_ready,
  input  logic                sdiv_out_valid,
  input  logic [2*DATA_W-1:0] sdiv_out_data,
  output logic                udiv_dend_valid,
  input  logic                udiv_dend_ready,
  output logic                udiv_dsor_valid,
  input  logic                udiv_dsor_ready,
  input  logic                udiv_out_valid,
  input  logic [2*DATA_W-1:0] udiv_out_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data
);

  state_t              state, state_nxt;
  logic                signed_q, quo_q, cancel;
  logic                accept, zero_div, issue_act, issue_clr;
  logic                dend_rdy, dsor_rdy, dend_v, dsor_v, dend_done, dsor_done;
  logic                out_vld;
  logic [2*DATA_W-1:0] out_dat;
  logic [DATA_W-1:0]   res_pick;
  logic                unused_op;

  // mod.wu is the remainder default, so its bit never steers anything.
  assign unused_op = req_op[OP_MOD_WU];

  always_comb begin
`ifdef DIV_ZERO_BYPASS_EN
    zero_div = (req_src2 == '0);
`else
    zero_div = 1'b0;
`endif
  end

  always_comb begin
    dend_rdy = signed_q ? sdiv_dend_ready : udiv_dend_ready;
    dsor_rdy = signed_q ? sdiv_dsor_ready : udiv_dsor_ready;
    out_vld  = signed_q ? sdiv_out_valid  : udiv_out_valid;
    out_dat  = signed_q ? sdiv_out_data   : udiv_out_data;
    res_pick = quo_q ? out_dat[QUO_HALF*DATA_W +: DATA_W]
                     : out_dat[REM_HALF*DATA_W +: DATA_W];
  end

  div_chan_issue u_dend (
    .clk   (clk),
    .rst   (rst),
    .active(issue_act),
    .clr   (issue_clr),
    .ready (dend_rdy),
    .valid (dend_v),
    .done  (dend_done)
  );

  div_chan_issue u_dsor (
    .clk   (clk),
    .rst   (rst),
    .active(issue_act),
    .clr   (issue_clr),
    .ready (dsor_rdy),
    .valid (dsor_v),
    .done  (dsor_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = zero_div ? S_DONE : S_ISSUE;
      S_ISSUE: if (dend_done && dsor_done) state_nxt = S_WAIT;
      S_WAIT:  if (out_vld) state_nxt = S_DONE;
      S_DONE:  if (cancel || flush || res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state == S_IDLE) & ~flush & ~rst;
    accept          = req_valid & req_ready;
    issue_act       = (state == S_ISSUE);
    issue_clr       = issue_act & dend_done & dsor_done;
    res_valid       = (state == S_DONE) & ~cancel;
    sdiv_dend_valid = dend_v & signed_q;
    sdiv_dsor_valid = dsor_v & signed_q;
    udiv_dend_valid = dend_v & ~signed_q;
    udiv_dsor_valid = dsor_v & ~signed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      signed_q     <= 1'b0;
      quo_q        <= 1'b0;
      res_data     <= '0;
      cancel       <= 1'b0;
    end else begin
      if (accept) begin
        div_dividend <= req_src1;
        div_divisor  <= req_src2;
        signed_q     <= op_is_signed(req_op);
        quo_q        <= op_wants_quo(req_op);
        if (zero_div) res_data <= op_wants_quo(req_op) ? '1 : req_src1;
      end
      if (state == S_WAIT && out_vld) res_data <= res_pick;
      // A cancelled request still runs to DONE so the divider drains first.
      if ((state == S_ISSUE || state == S_WAIT) && flush) begin
        cancel <= 1'b1;
      end else if (state == S_DONE) begin
        cancel <= 1'b0;
      end
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequences the two multi-cycle 32-bit divider units (signed and unsigned) on behalf of the EX stage.
- Accepts one division request at a time from EX.
- Drives each divider's independent dividend and divisor valid/ready channels, and waits for the divider output.
- Holds the selected quotient or remainder on a valid/ready result channel until the MEM/WB side consumes it; supports pipeline flush.

Parameters:
- DATA_W, 32, operand and result width; divider output is 2*DATA_W, quotient in the high half, remainder in the low half.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  EX has a division request
- req_ready  out  1  controller accepts a request this cycle
- req_op  in  4  one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu
- req_src1  in  DATA_W  dividend
- req_src2  in  DATA_W  divisor
- flush  in  1  cancel the in-flight request
- div_dividend  out  DATA_W  registered dividend, shared by both units
- div_divisor  out  DATA_W  registered divisor, shared by both units
- sdiv_dend_valid / sdiv_dend_ready  out/in  1/1  signed unit, dividend channel
- sdiv_dsor_valid / sdiv_dsor_ready  out/in  1/1  signed unit, divisor channel
- sdiv_out_valid  in  1  signed result valid
- sdiv_out_data  in  2*DATA_W  {quotient, remainder}
- udiv_dend_valid, udiv_dend_ready, udiv_dsor_valid, udiv_dsor_ready, udiv_out_valid, udiv_out_data  same as sdiv_*, for the unsigned unit
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  DATA_W  selected quotient or remainder

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset: state=IDLE; all *_valid=0; res_valid=0; res_data=0; div_dividend=0; div_divisor=0; cancel=0. The divider units share rst, so reset mid-operation abandons everything cleanly.
- req_ready = (state==IDLE) & ~flush & ~rst.
- IDLE: on req_valid&req_ready, register the operands, op, and unit select (signed = op[0]|op[1]); go to ISSUE.
- ISSUE:
  - Assert dend_valid and dsor_valid of the selected unit only.
  - Per channel, a sticky "accepted" flag sets on valid&ready and drops that channel's valid the next cycle. The two channels may complete in any order or in the same cycle.
  - Once both flags are set (or both handshakes complete this cycle), go to WAIT; the flags clear on leaving ISSUE.
  - A valid, once raised, stays high until accepted, even under flush.
- WAIT: on the selected unit's out_valid, capture res_data (quotient = high half for op[0]|op[2]; remainder = low half otherwise); go to DONE. The unselected unit's out_valid is ignored.
- DONE:
  - res_valid=1; res_data is stable until the handshake.
  - On res_valid&res_ready, go to IDLE and clear res_valid.
- Latency, all readys high: request accepted at cycle T; valids high at T+1; WAIT at T+2; out_valid at cycle X gives res_valid at X+1.
- Flush:
  - In ISSUE or WAIT: set cancel; the sequence continues so the divider drains.
  - On reaching DONE with cancel set: return to IDLE without asserting res_valid; clear cancel.
  - In DONE: go to IDLE the next cycle and drop res_valid. Flush and res_ready in the same cycle count as no handshake.
  - In IDLE: the request is not accepted.
- Back-to-back: a new request is accepted only in IDLE, so earliest is the cycle after the result handshake.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined: a divisor of 0 at accept goes IDLE -> DONE directly, with no divider channel asserted. Result: div = all-ones, mod = dividend; res_valid at T+1.
- Not defined: zero divisors go to the divider like any other value; the result is whatever the unit returns.

Decomposition:
- Package div_ctrl_pkg holds:
  - the state enum;
  - the req_op bit-index constants (OP_DIV_W, OP_MOD_W, OP_DIV_WU, OP_MOD_WU);
  - the quotient/remainder slice positions.
- One sub-module, div_chan_issue: a single valid/ready issuer with a sticky accepted flag, instantiated twice (dividend, divisor) and muxed onto the selected unit.

Test Plan:
- div.w, src1=-7, src2=2; sdiv readys high; sdiv_out_valid 5 cycles later with {-3, -1} -> res_data=0xFFFFFFFD one cycle after out_valid; udiv valids never assert.
- mod.wu, src1=0xFFFFFFFF, src2=0x10; udiv_dsor_ready delayed 3 cycles after udiv_dend_ready -> dend_valid drops after its handshake, dsor_valid held; res_data=0xF.
- Both channels accepted in the same cycle -> WAIT next cycle; flush during WAIT -> out_valid consumed, res_valid stays 0, req_ready=1 the following cycle.
- res_ready low for 4 cycles in DONE -> res_valid and res_data stable; the pulse on res_ready -> IDLE; a new request accepted the next cycle.
- Reset asserted in ISSUE -> next cycle all valids 0, state IDLE, res_data=0.
- DIV_ZERO_BYPASS_EN, div.wu 5/0 -> no channel valid; res_data=0xFFFFFFFF at T+1. mod.w 5/0 -> res_data=5.
